// File: rtl/dmem_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_ctrl
//
// Load/store controller that sits between a core's data port and a
// word-organised data-memory array. One request is taken at a time:
//
//   IDLE   -> request accepted, its fields captured
//   ACCESS -> memory driven from the captured request for one cycle
//   RESP   -> one-cycle completion pulse carrying the extended load data
//
// This gives two cycles from the accept edge to the response. The best
// throughput is one request every three cycles.
//
// Byte-lane handling is done here, so the memory array only sees
// word-aligned addresses:
//   - Stores replicate the data across the lanes and drive a byte mask.
//   - Loads read the whole word. The controller then selects the addressed
//     lane and extends it.
//
// Optional feature (macro DMEM_MISALIGN_TRAP_EN):
//   When the macro is defined, a misaligned access skips the memory access
//   and goes from IDLE straight to RESP. That response has
//   rsp_fault_o = 1 and rsp_rdata_o = 0.
//   A half access is misaligned when addr[0] = 1. A word access is
//   misaligned when addr[1:0] != 0.
//   When the macro is undefined, the misaligned low address bits are
//   ignored and rsp_fault_o is tied to 0.
//
// Ports
//   clk_i           single clock, rising edge
//   rst_n_i         asynchronous active-low reset
//   req_valid_i     request present
//   req_ready_o     controller can accept (high only in IDLE)
//   req_we_i        1 = store, 0 = load
//   req_size_i      00 byte, 01 half, 10/11 word
//   req_unsigned_i  load zero-extends when 1, sign-extends when 0
//   req_addr_i      byte address
//   req_wdata_i     right-justified store data
//   rsp_valid_o     one-cycle completion pulse
//   rsp_rdata_o     extended load data (0 for stores and faults)
//   rsp_fault_o     misaligned-access fault, qualified by rsp_valid_o
//   mem_addr_o      word-aligned address to the array
//   mem_wr_data_o   lane-replicated write data
//   mem_bytemask_o  byte-lane write enables
//   mem_write_en_o  write strobe
//   mem_read_en_o   read strobe
//   mem_rd_data_i   registered read data, valid the cycle after the strobe
// ---------------------------------------------------------------------------
module dmem_ctrl #(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_fault_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wr_data_o,
    output logic [3:0]            mem_bytemask_o,
    output logic                  mem_write_en_o,
    output logic                  mem_read_en_o,
    input  logic [31:0]           mem_rd_data_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    state_t                state_q;
    state_t                state_d;

    logic                  we_q;
    logic [1:0]            size_q;
    logic                  unsigned_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;

    logic                  accept;
    logic                  misalign_in;

    assign accept = (state_q == IDLE) && req_valid_i;

    // A misaligned request is detected on the incoming fields. The result
    // decides, in the same cycle, whether the request skips ACCESS. In the
    // default build nothing is ever misaligned, and the low address bits
    // are simply ignored by the lane logic further down.
`ifdef DMEM_MISALIGN_TRAP_EN
    always_comb begin
        misalign_in = 1'b0;
        if (req_size_i == SIZE_HALF) begin
            misalign_in = req_addr_i[0];
        end else if (req_size_i[1]) begin
            misalign_in = (req_addr_i[1:0] != 2'b00);
        end
    end
`else
    assign misalign_in = 1'b0;
`endif

    // State register. The asynchronous reset returns to IDLE at once.
    // Every output is decoded from this state, so a reset in the middle of
    // ACCESS or RESP blanks the memory strobes and the response right away.
    // Nothing from the interrupted request survives the reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    //   - IDLE waits for a request. An aligned request (or any request in
    //     the default build) goes through ACCESS. A trapped one jumps
    //     straight to RESP.
    //   - ACCESS and RESP each last exactly one cycle.
    //   - There is no response backpressure.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    state_d = misalign_in ? RESP : ACCESS;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture. The fields are loaded only on the accept cycle.
    // They then stay stable while ACCESS drives the memory and while RESP
    // extracts the load lane.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
        end else if (accept) begin
            we_q       <= req_we_i;
            size_q     <= req_size_i;
            unsigned_q <= req_unsigned_i;
            addr_q     <= req_addr_i;
            wdata_q    <= req_wdata_i;
        end
    end

    // The fault flag travels with the request into RESP. It exists only
    // when trapping is built in. Otherwise the fault output is a constant.
`ifdef DMEM_MISALIGN_TRAP_EN
    logic fault_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fault_q <= 1'b0;
        end else if (accept) begin
            fault_q <= misalign_in;
        end
    end

    assign rsp_fault_o = (state_q == RESP) && fault_q;
`else
    assign rsp_fault_o = 1'b0;
`endif

    assign req_ready_o = (state_q == IDLE);

    // Memory-side drive. Everything is held at 0 outside ACCESS, so the
    // array only ever sees a strobe together with a settled address.
    //
    // Stores:
    //   - The data is replicated so every lane carries the right bytes.
    //   - The mask picks which lanes are written.
    //   - A half store only looks at addr[1]. A word store always writes
    //     all four lanes.
    //
    // Loads:
    //   - The read strobe is raised with an all-zero mask.
    always_comb begin
        mem_addr_o     = '0;
        mem_wr_data_o  = 32'h0;
        mem_bytemask_o = 4'b0000;
        mem_write_en_o = 1'b0;
        mem_read_en_o  = 1'b0;
        if (state_q == ACCESS) begin
            mem_addr_o = {addr_q[ADDR_WIDTH-1:2], 2'b00};
            if (we_q) begin
                mem_write_en_o = 1'b1;
                case (size_q)
                    SIZE_BYTE: begin
                        mem_bytemask_o = 4'b0001 << addr_q[1:0];
                        mem_wr_data_o  = {4{wdata_q[7:0]}};
                    end
                    SIZE_HALF: begin
                        mem_bytemask_o = addr_q[1] ? 4'b1100 : 4'b0011;
                        mem_wr_data_o  = {2{wdata_q[15:0]}};
                    end
                    default: begin
                        mem_bytemask_o = 4'b1111;
                        mem_wr_data_o  = wdata_q;
                    end
                endcase
            end else begin
                mem_read_en_o = 1'b1;
            end
        end
    end

    // Load lane extraction. The memory returns the whole word during RESP.
    // The controller picks the byte or half selected by the captured
    // address and extends it according to the captured unsigned flag.
    // Stores, faults and every state other than RESP return 0.
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_data;

    always_comb begin
        case (addr_q[1:0])
            2'd0:    sel_byte = mem_rd_data_i[7:0];
            2'd1:    sel_byte = mem_rd_data_i[15:8];
            2'd2:    sel_byte = mem_rd_data_i[23:16];
            default: sel_byte = mem_rd_data_i[31:24];
        endcase
        sel_half = addr_q[1] ? mem_rd_data_i[31:16] : mem_rd_data_i[15:0];

        case (size_q)
            SIZE_BYTE: load_data = {{24{sel_byte[7] & ~unsigned_q}}, sel_byte};
            SIZE_HALF: load_data = {{16{sel_half[15] & ~unsigned_q}}, sel_half};
            default:   load_data = mem_rd_data_i;
        endcase
    end

    // Response drive. The pulse is high for the single RESP cycle only.
    always_comb begin
        rsp_valid_o = 1'b0;
        rsp_rdata_o = 32'h0;
        if (state_q == RESP) begin
            rsp_valid_o = 1'b1;
            if (!we_q && !rsp_fault_o) begin
                rsp_rdata_o = load_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_ctrl
//
// Directed bench for dmem_ctrl with a small word-organised memory model.
// The model writes by byte mask and returns registered read data. Inputs
// change on the falling edge and outputs are sampled there as well.
// Build with +define+DMEM_MISALIGN_TRAP_EN to cover the trapping variant.
// ---------------------------------------------------------------------------
module tb_dmem_ctrl;

    localparam int AW = 11;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_we_i;
    logic [1:0]    req_size_i;
    logic          req_unsigned_i;
    logic [AW-1:0] req_addr_i;
    logic [31:0]   req_wdata_i;
    logic          rsp_valid_o;
    logic [31:0]   rsp_rdata_o;
    logic          rsp_fault_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wr_data_o;
    logic [3:0]    mem_bytemask_o;
    logic          mem_write_en_o;
    logic          mem_read_en_o;
    logic [31:0]   mem_rd_data_i;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [0:511];

    dmem_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_fault_o    (rsp_fault_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wr_data_o  (mem_wr_data_o),
        .mem_bytemask_o (mem_bytemask_o),
        .mem_write_en_o (mem_write_en_o),
        .mem_read_en_o  (mem_read_en_o),
        .mem_rd_data_i  (mem_rd_data_i)
    );

    always #5 clk_i = ~clk_i;

    // Memory array model with registered reads.
    always @(posedge clk_i) begin
        if (mem_write_en_o) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_bytemask_o[b]) mem[mem_addr_o[10:2]][b*8 +: 8] <= mem_wr_data_o[b*8 +: 8];
            end
        end
        if (mem_read_en_o) mem_rd_data_i <= mem[mem_addr_o[10:2]];
    end

    // Present one request on a falling edge and hold it across the accept edge.
    // Returns at the falling edge after the accept edge.
    task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [AW-1:0] addr, input logic [31:0] wdata);
        @(negedge clk_i);
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
    endtask

    // Aligned word store followed by the RESP and IDLE cycles.
    task automatic preload_word(input logic [AW-1:0] addr, input logic [31:0] data);
        drive_req(1'b1, 2'b10, 1'b0, addr, data);
        @(negedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic test_reset;
        rst_n_i = 1'b0;
        #1;
        n_cmp++; if (req_ready_o !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_ready got %b want 1", req_ready_o); end
        n_cmp++; if (rsp_valid_o !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_rsp_valid got %b want 0", rsp_valid_o); end
        n_cmp++; if (rsp_rdata_o !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_rdata got %h want 0", rsp_rdata_o); end
        n_cmp++; if ({mem_write_en_o, mem_read_en_o, mem_bytemask_o} !== 6'b0) begin n_bad++; $display("[TB] FAIL reset_mem_strobes got %b want 0", {mem_write_en_o, mem_read_en_o, mem_bytemask_o}); end
        n_cmp++; if (mem_addr_o !== '0) begin n_bad++; $display("[TB] FAIL reset_mem_addr got %h want 0", mem_addr_o); end
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_store_word;
        drive_req(1'b1, 2'b10, 1'b0, 11'h010, 32'hDEADBEEF);
        n_cmp++; if (mem_addr_o !== 11'h010) begin n_bad++; $display("[TB] FAIL sw_addr got %h want 010", mem_addr_o); end
        n_cmp++; if (mem_bytemask_o !== 4'b1111) begin n_bad++; $display("[TB] FAIL sw_mask got %b want 1111", mem_bytemask_o); end
        n_cmp++; if (mem_write_en_o !== 1'b1 || mem_read_en_o !== 1'b0) begin n_bad++; $display("[TB] FAIL sw_strobes got we=%b re=%b want we=1 re=0", mem_write_en_o, mem_read_en_o); end
        n_cmp++; if (mem_wr_data_o !== 32'hDEADBEEF) begin n_bad++; $display("[TB] FAIL sw_wdata got %h want deadbeef", mem_wr_data_o); end
        n_cmp++; if (req_ready_o !== 1'b0 || rsp_valid_o !== 1'b0) begin n_bad++; $display("[TB] FAIL sw_access_flags got rdy=%b vld=%b want 0 0", req_ready_o, rsp_valid_o); end
        @(negedge clk_i);
        n_cmp++; if (rsp_valid_o !== 1'b1) begin n_bad++; $display("[TB] FAIL sw_rsp_valid got %b want 1", rsp_valid_o); end
        n_cmp++; if (rsp_rdata_o !== 32'h0 || rsp_fault_o !== 1'b0) begin n_bad++; $display("[TB] FAIL sw_rsp_data got %h/%b want 0/0", rsp_rdata_o, rsp_fault_o); end
        n_cmp++; if (mem_write_en_o !== 1'b0 || mem_bytemask_o !== 4'b0) begin n_bad++; $display("[TB] FAIL sw_resp_strobes got we=%b mask=%b want 0", mem_write_en_o, mem_bytemask_o); end
        @(negedge clk_i);
        n_cmp++; if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin n_bad++; $display("[TB] FAIL sw_back_idle got rdy=%b vld=%b want 1 0", req_ready_o, rsp_valid_o); end
    endtask

    task automatic test_byte;
        drive_req(1'b1, 2'b00, 1'b0, 11'h013, 32'h000000A5);
        n_cmp++; if (mem_bytemask_o !== 4'b1000) begin n_bad++; $display("[TB] FAIL sb_mask got %b want 1000", mem_bytemask_o); end
        n_cmp++; if (mem_wr_data_o !== 32'hA5A5A5A5) begin n_bad++; $display("[TB] FAIL sb_wdata got %h want a5a5a5a5", mem_wr_data_o); end
        n_cmp++; if (mem_addr_o !== 11'h010) begin n_bad++; $display("[TB] FAIL sb_addr got %h want 010", mem_addr_o); end
        repeat (2) @(negedge clk_i);
        drive_req(1'b0, 2'b00, 1'b0, 11'h013, 32'h0);
        n_cmp++; if (mem_read_en_o !== 1'b1 || mem_write_en_o !== 1'b0 || mem_bytemask_o !== 4'b0) begin n_bad++; $display("[TB] FAIL lb_strobes got re=%b we=%b mask=%b want 1 0 0000", mem_read_en_o, mem_write_en_o, mem_bytemask_o); end
        @(negedge clk_i);
        n_cmp++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hFFFFFFA5) begin n_bad++; $display("[TB] FAIL lb_signed got %b/%h want 1/ffffffa5", rsp_valid_o, rsp_rdata_o); end
        @(negedge clk_i);
        drive_req(1'b0, 2'b00, 1'b1, 11'h013, 32'h0);
        @(negedge clk_i);
        n_cmp++; if (rsp_rdata_o !== 32'h000000A5) begin n_bad++; $display("[TB] FAIL lbu got %h want 000000a5", rsp_rdata_o); end
        @(negedge clk_i);
        // Byte 1 of 0xA5ADBEEF is 0xBE.
        drive_req(1'b0, 2'b00, 1'b0, 11'h011, 32'h0);
        @(negedge clk_i);
        n_cmp++; if (rsp_rdata_o !== 32'hFFFFFFBE) begin n_bad++; $display("[TB] FAIL lb_lane1 got %h want ffffffbe", rsp_rdata_o); end
        @(negedge clk_i);
    endtask

    task automatic test_half;
        preload_word(11'h000, 32'h80017FFF);
        drive_req(1'b0, 2'b01, 1'b0, 11'h002, 32'h0);
        @(negedge clk_i);
        n_cmp++; if (rsp_rdata_o !== 32'hFFFF8001) begin n_bad++; $display("[TB] FAIL lh_002 got %h want ffff8001", rsp_rdata_o); end
        @(negedge clk_i);
        drive_req(1'b0, 2'b01, 1'b0, 11'h000, 32'h0);
        @(negedge clk_i);
        n_cmp++; if (rsp_rdata_o !== 32'h00007FFF) begin n_bad++; $display("[TB] FAIL lh_000 got %h want 00007fff", rsp_rdata_o); end
        @(negedge clk_i);
        drive_req(1'b0, 2'b01, 1'b1, 11'h002, 32'h0);
        @(negedge clk_i);
        n_cmp++; if (rsp_rdata_o !== 32'h00008001) begin n_bad++; $display("[TB] FAIL lhu_002 got %h want 00008001", rsp_rdata_o); end
        @(negedge clk_i);
        drive_req(1'b1, 2'b01, 1'b0, 11'h002, 32'h0000BEEF);
        n_cmp++; if (mem_bytemask_o !== 4'b1100 || mem_wr_data_o !== 32'hBEEFBEEF) begin n_bad++; $display("[TB] FAIL sh_002 got %b/%h want 1100/beefbeef", mem_bytemask_o, mem_wr_data_o); end
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_misalign;
        preload_word(11'h004, 32'h12345678);
        drive_req(1'b0, 2'b10, 1'b0, 11'h006, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
        n_cmp++; if (rsp_valid_o !== 1'b1 || rsp_fault_o !== 1'b1 || rsp_rdata_o !== 32'h0) begin n_bad++; $display("[TB] FAIL lw_trap got %b/%b/%h want 1/1/0", rsp_valid_o, rsp_fault_o, rsp_rdata_o); end
        n_cmp++; if ({mem_read_en_o, mem_write_en_o, mem_bytemask_o} !== 6'b0) begin n_bad++; $display("[TB] FAIL lw_trap_strobes got %b want 0", {mem_read_en_o, mem_write_en_o, mem_bytemask_o}); end
        @(negedge clk_i);
        n_cmp++; if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin n_bad++; $display("[TB] FAIL lw_trap_idle got %b/%b want 1/0", req_ready_o, rsp_valid_o); end
        drive_req(1'b0, 2'b01, 1'b0, 11'h003, 32'h0);
        n_cmp++; if (rsp_fault_o !== 1'b1 || mem_read_en_o !== 1'b0) begin n_bad++; $display("[TB] FAIL lh_trap got fault=%b re=%b want 1 0", rsp_fault_o, mem_read_en_o); end
        @(negedge clk_i);
`else
        n_cmp++; if (mem_read_en_o !== 1'b1 || mem_addr_o !== 11'h004) begin n_bad++; $display("[TB] FAIL lw_mis_access got %b/%h want 1/004", mem_read_en_o, mem_addr_o); end
        @(negedge clk_i);
        n_cmp++; if (rsp_rdata_o !== 32'h12345678 || rsp_fault_o !== 1'b0) begin n_bad++; $display("[TB] FAIL lw_mis_data got %h/%b want 12345678/0", rsp_rdata_o, rsp_fault_o); end
        @(negedge clk_i);
        // Only addr[1] matters here, so the upper half 0xBEEF is returned.
        drive_req(1'b0, 2'b01, 1'b0, 11'h003, 32'h0);
        @(negedge clk_i);
        n_cmp++; if (rsp_rdata_o !== 32'hFFFFBEEF || rsp_fault_o !== 1'b0) begin n_bad++; $display("[TB] FAIL lh_mis_data got %h/%b want ffffbeef/0", rsp_rdata_o, rsp_fault_o); end
        @(negedge clk_i);
`endif
    endtask

    task automatic test_reset_mid;
        int pulses;
        preload_word(11'h020, 32'hCAFEF00D);
        drive_req(1'b1, 2'b10, 1'b0, 11'h020, 32'h11223344);
        n_cmp++; if (mem_write_en_o !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_pre_access got %b want 1", mem_write_en_o); end
        rst_n_i = 1'b0;
        #1;
        n_cmp++; if ({mem_write_en_o, mem_bytemask_o, mem_wr_data_o} !== 37'h0 || mem_addr_o !== '0) begin n_bad++; $display("[TB] FAIL rst_access_outputs got we=%b mask=%b wd=%h a=%h want 0", mem_write_en_o, mem_bytemask_o, mem_wr_data_o, mem_addr_o); end
        n_cmp++; if (req_ready_o !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_access_ready got %b want 1", req_ready_o); end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        pulses = 0;
        repeat (4) begin
            @(negedge clk_i);
            if (rsp_valid_o === 1'b1) pulses++;
        end
        n_cmp++; if (pulses != 0) begin n_bad++; $display("[TB] FAIL rst_no_rsp got %0d pulses want 0", pulses); end
        n_cmp++; if (req_ready_o !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_release_ready got %b want 1", req_ready_o); end
        drive_req(1'b0, 2'b10, 1'b0, 11'h020, 32'h0);
        @(negedge clk_i);
        n_cmp++; if (rsp_rdata_o !== 32'hCAFEF00D) begin n_bad++; $display("[TB] FAIL rst_store_dropped got %h want cafef00d", rsp_rdata_o); end
        rst_n_i = 1'b0;
        #1;
        n_cmp++; if (rsp_valid_o !== 1'b0 || rsp_rdata_o !== 32'h0) begin n_bad++; $display("[TB] FAIL rst_resp_outputs got %b/%h want 0/0", rsp_valid_o, rsp_rdata_o); end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_back_to_back;
        int          acc_cyc [3];
        logic [31:0] exp_data [3];
        int          idx;
        int          rsp_n;
        exp_data[0] = 32'h0A0B0C0D;
        exp_data[1] = 32'h11112222;
        exp_data[2] = 32'hF0F0F0F0;
        for (int i = 0; i < 3; i++) preload_word(AW'(11'h040 + 4 * i), exp_data[i]);
        idx   = 0;
        rsp_n = 0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            @(negedge clk_i);
            if (rsp_valid_o === 1'b1) begin
                if (rsp_n < 3) begin
                    n_cmp++; if (rsp_rdata_o !== exp_data[rsp_n]) begin n_bad++; $display("[TB] FAIL b2b_data%0d got %h want %h", rsp_n, rsp_rdata_o, exp_data[rsp_n]); end
                end
                rsp_n++;
            end
            req_we_i       = 1'b0;
            req_size_i     = 2'b10;
            req_unsigned_i = 1'b0;
            req_addr_i     = AW'(11'h040 + 4 * idx);
            req_valid_i    = (idx < 3);
            if (req_ready_o === 1'b1 && idx < 3) begin
                acc_cyc[idx] = cyc;
                idx++;
            end
        end
        req_valid_i = 1'b0;
        n_cmp++; if (idx != 3) begin n_bad++; $display("[TB] FAIL b2b_accepts got %0d want 3", idx); end
        if (idx == 3) begin
            n_cmp++; if (acc_cyc[1] - acc_cyc[0] != 3 || acc_cyc[2] - acc_cyc[1] != 3) begin n_bad++; $display("[TB] FAIL b2b_spacing got %0d,%0d want 3,3", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]); end
        end
        n_cmp++; if (rsp_n != 3) begin n_bad++; $display("[TB] FAIL b2b_rsp_count got %0d want 3", rsp_n); end
    endtask

    initial begin
        req_valid_i    = 1'b0;
        req_we_i       = 1'b0;
        req_size_i     = 2'b00;
        req_unsigned_i = 1'b0;
        req_addr_i     = '0;
        req_wdata_i    = 32'h0;
        test_reset();
        test_store_word();
        test_byte();
        test_half();
        test_misalign();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
